// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
// Imported by the interface, the dump sequencer and the top.
package regfile_pkg;

   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_ADDR_W = 4;

   typedef enum logic {
      DUMP_IDLE = 1'b0,
      DUMP_RUN  = 1'b1
   } dump_state_t;

endpackage

// File: rtl/register_file_param_if.sv
// Bus bundle for the register file: decode read ports, write-back port,
// fetch PC input and the debug dump stream.
interface register_file_param_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W
);

   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;
   logic              wr_enable;
   logic [DATA_W-1:0] RI15;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;

   logic              dump_start;
   logic              dump_ready;
   logic              dump_valid;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;
   logic              dump_busy;

   modport master (
      output A1, A2, A3, WD3, wr_enable, RI15, dump_start, dump_ready,
      input  RD1, RD2, dump_valid, dump_addr, dump_data, dump_last, dump_busy
   );

   modport slave (
      input  A1, A2, A3, WD3, wr_enable, RI15, dump_start, dump_ready,
      output RD1, RD2, dump_valid, dump_addr, dump_data, dump_last, dump_busy
   );

endinterface

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks every register index once over a valid/ready stream.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   DUMP_IDLE | no dump in progress; outputs quiet, waits for dump_start
//   DUMP_RUN  | presenting beat cnt; advances on handshake, exits after last
module regfile_dump_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REGFILE_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic              dump_busy,
   output logic              dump_last,
   output logic [ADDR_W-1:0] dump_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   dump_state_t       state;
   dump_state_t       state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DUMP_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_last  = 1'b0;
      dump_addr  = '0;
      case (state)
         DUMP_IDLE: begin
            if (dump_start) begin
               state_nxt = DUMP_RUN;
               cnt_nxt   = '0;
            end
         end
         DUMP_RUN: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            dump_addr  = cnt;
            dump_last  = (cnt == LAST_IDX);
            // dump_start is deliberately not looked at here: no restart, no queueing
            if (dump_ready) begin
               if (cnt == LAST_IDX) begin
                  state_nxt = DUMP_IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = DUMP_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// PC slot sourced from fetch, optional write bypass and a debug dump stream.
module register_file_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W,
   parameter int PC_IDX = (1 << ADDR_W) - 1,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   register_file_param_if.slave  bus
);

   localparam int                NUM_REGS = 1 << ADDR_W;
   localparam int                NUM_PORTS = 3;
   localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_gen;
   logic [ADDR_W-1:0] rd_addr [NUM_PORTS];

   logic              seq_valid;
   logic              seq_busy;
   logic              seq_last;
   logic [ADDR_W-1:0] seq_addr;

   // The PC slot is never written, so its storage folds away.
   assign wr_gen = bus.wr_enable && (bus.A3 != PC_ADDR);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_gen) begin
         regs[bus.A3] <= bus.WD3;
      end
   end

   regfile_dump_seq #(
      .ADDR_W (ADDR_W)
   ) u_dump_seq (
      .clk        (clk),
      .reset      (reset),
      .dump_start (bus.dump_start),
      .dump_ready (bus.dump_ready),
      .dump_valid (seq_valid),
      .dump_busy  (seq_busy),
      .dump_last  (seq_last),
      .dump_addr  (seq_addr)
   );

   assign rd_addr[0] = bus.A1;
   assign rd_addr[1] = bus.A2;
   assign rd_addr[2] = seq_addr;

   // Port 2 is the dump mux; it sees the same PC and bypass rules as decode.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      logic [DATA_W-1:0] val;
      always_comb begin
         val = regs[rd_addr[p]];
         if ((BYPASS != 0) && wr_gen && (bus.A3 == rd_addr[p])) begin
            val = bus.WD3;
         end
         if (rd_addr[p] == PC_ADDR) begin
            val = bus.RI15;
         end
      end
   end

   assign bus.RD1        = g_rd[0].val;
   assign bus.RD2        = g_rd[1].val;
   assign bus.dump_valid = seq_valid;
   assign bus.dump_busy  = seq_busy;
   assign bus.dump_last  = seq_last;
   assign bus.dump_addr  = seq_addr;
   assign bus.dump_data  = seq_valid ? g_rd[2].val : '0;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// checked against an array model of the register file and dump stream.
module tb_register_file_param;
   import regfile_pkg::*;

   localparam int         DW   = 32;
   localparam int         AW   = 4;
   localparam int         NR   = 16;
   localparam logic [3:0] PC_A = 4'd15;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
   register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

   assign bus_b.A1         = bus_a.A1;
   assign bus_b.A2         = bus_a.A2;
   assign bus_b.A3         = bus_a.A3;
   assign bus_b.WD3        = bus_a.WD3;
   assign bus_b.wr_enable  = bus_a.wr_enable;
   assign bus_b.RI15       = bus_a.RI15;
   assign bus_b.dump_start = bus_a.dump_start;
   assign bus_b.dump_ready = bus_a.dump_ready;

   register_file_param #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(15), .BYPASS(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   register_file_param #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(15), .BYPASS(0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   typedef struct {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [31:0] b1;
      logic [31:0] b2;
   } rd_exp_t;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic valid;
      logic busy;
   } stat_t;

   rd_exp_t     rd_q   [$];
   beat_t       dump_q [$];
   stat_t       stat_q [$];
   logic [31:0] model  [NR];
   int          tests  = 0;
   int          failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a, input bit byp);
      if (a == PC_A) return bus_a.RI15;
      if (byp && bus_a.wr_enable && bus_a.A3 == a) return bus_a.WD3;
      return model[a];
   endfunction

   task automatic push_reads();
      rd_exp_t e;
      e.a1 = model_read(bus_a.A1, 1'b1);
      e.a2 = model_read(bus_a.A2, 1'b1);
      e.b1 = model_read(bus_a.A1, 1'b0);
      e.b2 = model_read(bus_a.A2, 1'b0);
      rd_q.push_back(e);
   endtask

   task automatic push_stat(input logic v, input logic b);
      stat_t s;
      s.valid = v;
      s.busy  = b;
      stat_q.push_back(s);
   endtask

   task automatic push_beats(input int n);
      beat_t bt;
      for (int k = 0; k < n; k++) begin
         bt.addr = 4'(k);
         bt.data = (4'(k) == PC_A) ? bus_a.RI15 : model[k];
         bt.last = (k == NR - 1);
         dump_q.push_back(bt);
      end
   endtask

   // Advance one edge; the model takes the write that the edge commits.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < NR; i++) model[i] = '0;
      end else if (bus_a.wr_enable && bus_a.A3 != PC_A) begin
         model[bus_a.A3] = bus_a.WD3;
      end
      #1;
   endtask

   task automatic step();
      push_reads();
      tick();
   endtask

   always @(negedge clk) begin
      rd_exp_t e;
      stat_t   s;
      beat_t   bt;
      while (rd_q.size() > 0) begin
         e = rd_q.pop_front();
         check("rd1_bypass",   bus_a.RD1, e.a1);
         check("rd2_bypass",   bus_a.RD2, e.a2);
         check("rd1_nobypass", bus_b.RD1, e.b1);
         check("rd2_nobypass", bus_b.RD2, e.b2);
      end
      while (stat_q.size() > 0) begin
         s = stat_q.pop_front();
         check("dump_valid", 32'(bus_a.dump_valid), 32'(s.valid));
         check("dump_busy",  32'(bus_a.dump_busy),  32'(s.busy));
         if (!s.valid) begin
            check("idle_addr", 32'(bus_a.dump_addr), 32'd0);
            check("idle_data", bus_a.dump_data, 32'd0);
            check("idle_last", 32'(bus_a.dump_last), 32'd0);
         end
      end
      if (bus_a.dump_valid && bus_a.dump_ready) begin
         if (dump_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_beat: got addr %0d expected no beat", bus_a.dump_addr);
         end else begin
            bt = dump_q.pop_front();
            check("beat_addr", 32'(bus_a.dump_addr), 32'(bt.addr));
            check("beat_data", bus_a.dump_data, bt.data);
            check("beat_last", 32'(bus_a.dump_last), 32'(bt.last));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int cyc;
      bus_a.A1         = '0;
      bus_a.A2         = '0;
      bus_a.A3         = '0;
      bus_a.WD3        = '0;
      bus_a.wr_enable  = 1'b0;
      bus_a.RI15       = 32'h100;
      bus_a.dump_start = 1'b0;
      bus_a.dump_ready = 1'b0;
      reset = 1'b1;
      tick();
      push_stat(1'b0, 1'b0);
      step();
      reset = 1'b0;

      // reset contents
      for (int a = 0; a < NR; a++) begin
         bus_a.A1 = 4'(a);
         bus_a.A2 = 4'(NR - 1 - a);
         push_stat(1'b0, 1'b0);
         step();
      end

      // write with same-cycle read, then the following cycle
      bus_a.A1 = 4'd3; bus_a.A2 = PC_A; bus_a.A3 = 4'd3;
      bus_a.WD3 = 32'hDEADBEEF; bus_a.wr_enable = 1'b1;
      step();
      bus_a.wr_enable = 1'b0;
      step();

      // write to the PC slot is dropped
      bus_a.RI15 = 32'h40; bus_a.A1 = PC_A; bus_a.A2 = 4'd3; bus_a.A3 = PC_A;
      bus_a.WD3 = 32'h1234; bus_a.wr_enable = 1'b1;
      step();
      bus_a.wr_enable = 1'b0;
      for (int a = 0; a < NR; a++) begin
         bus_a.A1 = 4'(a);
         bus_a.A2 = 4'(a ^ 5);
         step();
      end

      // random traffic with the dump idle
      for (int i = 0; i < 120; i++) begin
         bus_a.A1         = 4'($urandom_range(0, 15));
         bus_a.A2         = 4'($urandom_range(0, 15));
         bus_a.A3         = 4'($urandom_range(0, 15));
         bus_a.WD3        = $urandom;
         bus_a.wr_enable  = 1'($urandom_range(0, 1));
         bus_a.RI15       = $urandom;
         bus_a.dump_ready = 1'($urandom_range(0, 1));
         push_stat(1'b0, 1'b0);
         step();
      end

      // preload Rk = k*0x11
      for (int k = 0; k < NR - 1; k++) begin
         bus_a.A3 = 4'(k); bus_a.WD3 = 32'(k * 17); bus_a.wr_enable = 1'b1;
         step();
      end
      bus_a.wr_enable = 1'b0;
      bus_a.RI15 = 32'h200;

      // full dump with ready held high
      bus_a.dump_ready = 1'b1;
      bus_a.dump_start = 1'b1;
      push_stat(1'b0, 1'b0);
      step();
      bus_a.dump_start = 1'b0;
      push_beats(NR);
      for (int i = 0; i < NR; i++) begin
         push_stat(1'b1, 1'b1);
         step();
      end
      // first idle cycle: a new start is accepted at the next edge
      push_stat(1'b0, 1'b0);
      bus_a.dump_start = 1'b1;
      bus_a.dump_ready = 1'b0;
      step();
      bus_a.dump_start = 1'b0;

      // dump with ready toggling and restart attempts mid-dump
      push_beats(NR);
      hs  = 0;
      cyc = 0;
      while (hs < NR && cyc < 80) begin
         bus_a.dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         bus_a.dump_start = (cyc == 5) || (cyc == 9);
         push_stat(1'b1, 1'b1);
         if (bus_a.dump_ready) hs++;
         step();
         cyc++;
      end
      check("toggle_dump_handshakes", 32'(hs), 32'(NR));
      bus_a.dump_start = 1'b0;
      bus_a.dump_ready = 1'b1;
      push_stat(1'b0, 1'b0);
      step();

      // reset during beat 5, coincident with a write that must be lost
      bus_a.dump_start = 1'b1;
      push_stat(1'b0, 1'b0);
      step();
      bus_a.dump_start = 1'b0;
      push_beats(6);
      for (int i = 0; i < 6; i++) begin
         push_stat(1'b1, 1'b1);
         if (i == 5) begin
            reset = 1'b1;
            bus_a.A3 = 4'd7; bus_a.WD3 = 32'hABCD; bus_a.wr_enable = 1'b1;
         end
         step();
      end
      reset = 1'b0;
      bus_a.wr_enable = 1'b0;
      for (int a = 0; a < NR; a++) begin
         bus_a.A1 = 4'(a);
         bus_a.A2 = 4'(a);
         push_stat(1'b0, 1'b0);
         step();
      end

      // clean dump after the abandoned one
      bus_a.dump_start = 1'b1;
      step();
      bus_a.dump_start = 1'b0;
      push_beats(NR);
      for (int i = 0; i < NR; i++) begin
         push_stat(1'b1, 1'b1);
         step();
      end
      push_stat(1'b0, 1'b0);
      step();
      step();

      check("dump_queue_drained", 32'(dump_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
